// File: rtl/ping_pkg.sv
// Shared types and default constants for the multi-channel ultrasonic ping controller.
package ping_pkg;

    // Sequencer states; the controller walks these once per channel.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE_LOW   = 3'd1,
        ST_TRIG_HIGH = 3'd2,
        ST_POST_LOW  = 3'd3,
        ST_WAIT_RISE = 3'd4,
        ST_WAIT_FALL = 3'd5,
        ST_GAP       = 3'd6
    } ping_state_e;

    // Width of a channel index; never below 1 so a single-channel build still has a port.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_CH_DEF       = 4;
    localparam int CH_W_DEF         = ch_width(NUM_CH_DEF);
    localparam int CLK_PER_US_DEF   = 1;
    localparam int TRIG_LOW_US_DEF  = 5;
    localparam int TRIG_HIGH_US_DEF = 5;
    localparam int POST_LOW_US_DEF  = 5;
    localparam int TIMEOUT_US_DEF   = 6000;
    localparam int GAP_US_DEF       = 200;
    localparam int DIST_W_DEF       = 16;
    localparam int MM_SCALE_Q16_DEF = 11142;   // 0.5 * 0.340 mm/us in Q0.16

    // Timers and the echo counter are 16 bits; all durations must fit.
    localparam int TMR_W  = 16;
    localparam int ECHO_W = 16;

endpackage

// File: rtl/ping_edge_sync.sv
// Per-channel two-flop synchroniser with rise/fall pulses on the synchronised level.
module ping_edge_sync #(
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] din,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall
);

    logic [NUM_CH-1:0] sync1_q, sync1_d;
    logic [NUM_CH-1:0] sync2_q, sync2_d;
    logic [NUM_CH-1:0] prev_q,  prev_d;

    // Shift the pad level through the synchroniser and keep one cycle of history.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchroniser and history flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;

endmodule

// File: rtl/ping_array_ctrl.sv
// Round-robin sequencer for NUM_CH three-pin ultrasonic rangers on one timing engine.
// Result interface: dist_valid is a one-cycle strobe with no back-pressure; the consumer
// must capture dist_ch/dist_mm/dist_timeout on that cycle (they also hold until the next strobe).
module ping_array_ctrl
    import ping_pkg::*;
#(
    parameter int NUM_CH       = NUM_CH_DEF,
    parameter int CLK_PER_US   = CLK_PER_US_DEF,
    parameter int TRIG_LOW_US  = TRIG_LOW_US_DEF,
    parameter int TRIG_HIGH_US = TRIG_HIGH_US_DEF,
    parameter int POST_LOW_US  = POST_LOW_US_DEF,
    parameter int TIMEOUT_US   = TIMEOUT_US_DEF,
    parameter int GAP_US       = GAP_US_DEF,
    parameter int DIST_W       = DIST_W_DEF,
    parameter int MM_SCALE_Q16 = MM_SCALE_Q16_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUM_CH-1:0]           sensor_in,
    output logic [NUM_CH-1:0]           sensor_out,
    output logic [NUM_CH-1:0]           sensor_oe,
    output logic                        dist_valid,
    output logic [ch_width(NUM_CH)-1:0] dist_ch,
    output logic [DIST_W-1:0]           dist_mm,
    output logic                        dist_timeout,
    output logic                        busy,
    output ping_state_e                 dbg_state
);

    localparam int CW = ch_width(NUM_CH);
    // Largest distance representable on the output (DIST_W is at most 32).
    localparam logic [31:0] DIST_MAX = (DIST_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << DIST_W) - 32'd1);

    ping_state_e       state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [ECHO_W-1:0] echo_q, echo_d, echo_inc;
    logic [CW-1:0]     cur_ch_q, cur_ch_d;
    logic [NUM_CH-1:0] oe_q, oe_d, out_q, out_d;
    logic              dv_q, dv_d, to_q, to_d, busy_q, busy_d;
    logic [DIST_W-1:0] mm_q, mm_d;
    logic [CW-1:0]     dch_q, dch_d;
    logic [15:0]       presc_q, presc_d;
    logic              us_tick;
    logic [NUM_CH-1:0] rise, fall;
    logic              rise_sel, fall_sel, drive;
    logic [31:0]       prod, mm32;

    ping_edge_sync #(.NUM_CH(NUM_CH)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sensor_in),
        .rise  (rise),
        .fall  (fall)
    );

    assign rise_sel = rise[cur_ch_q];
    assign fall_sel = fall[cur_ch_q];

    // Prescaler: us_tick marks the last clk of each microsecond.
    always_comb begin
        us_tick = (presc_q == 16'(CLK_PER_US - 1));
        presc_d = us_tick ? '0 : presc_q + 16'd1;
    end

    // Prescaler flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) presc_q <= '0;
        else       presc_q <= presc_d;
    end

    // Echo width including the current tick, and its full-width millimetre conversion.
    always_comb begin
        echo_inc = (us_tick && echo_q != '1) ? echo_q + ECHO_W'(1) : echo_q;
        prod     = 32'(echo_inc) * 32'(MM_SCALE_Q16);
        mm32     = prod >> 16;
    end

    // Sequencer next state, timers, result capture and pad drive.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        echo_d   = echo_q;
        cur_ch_d = cur_ch_q;
        dv_d     = 1'b0;
        mm_d     = mm_q;
        dch_d    = dch_q;
        to_d     = to_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d  = ST_PRE_LOW;
                    cur_ch_d = '0;
                    tmr_d    = '0;
                end
            end
            ST_PRE_LOW, ST_TRIG_HIGH, ST_POST_LOW: begin
                if (us_tick) begin
                    if ((state_q == ST_PRE_LOW   && tmr_q == TMR_W'(TRIG_LOW_US - 1)) ||
                        (state_q == ST_TRIG_HIGH && tmr_q == TMR_W'(TRIG_HIGH_US - 1)) ||
                        (state_q == ST_POST_LOW  && tmr_q == TMR_W'(POST_LOW_US - 1))) begin
                        tmr_d   = '0;
                        state_d = (state_q == ST_PRE_LOW)   ? ST_TRIG_HIGH :
                                  (state_q == ST_TRIG_HIGH) ? ST_POST_LOW  : ST_WAIT_RISE;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
            end
            ST_WAIT_RISE: begin
                // The edge wins over a timeout landing in the same cycle.
                if (rise_sel) begin
                    state_d = ST_WAIT_FALL;
                    echo_d  = '0;
                    tmr_d   = '0;
                end else if (us_tick && tmr_q == TMR_W'(TIMEOUT_US - 1)) begin
                    state_d = ST_GAP;
                    tmr_d   = '0;
                    dv_d    = 1'b1;
                    dch_d   = cur_ch_q;
                    mm_d    = '1;
                    to_d    = 1'b1;
                end else if (us_tick) begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_WAIT_FALL: begin
                echo_d = echo_inc;
                if (fall_sel) begin
                    state_d = ST_GAP;
                    tmr_d   = '0;
                    dv_d    = 1'b1;
                    dch_d   = cur_ch_q;
                    mm_d    = (mm32 > DIST_MAX) ? '1 : DIST_W'(mm32);
                    to_d    = 1'b0;
                end else if (us_tick && tmr_q == TMR_W'(TIMEOUT_US - 1)) begin
                    state_d = ST_GAP;
                    tmr_d   = '0;
                    dv_d    = 1'b1;
                    dch_d   = cur_ch_q;
                    mm_d    = '1;
                    to_d    = 1'b1;
                end else if (us_tick) begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (us_tick) begin
                    if (tmr_q == TMR_W'(GAP_US - 1)) begin
                        tmr_d    = '0;
                        cur_ch_d = (cur_ch_q == CW'(NUM_CH - 1)) ? '0 : cur_ch_q + CW'(1);
                        state_d  = enable ? ST_PRE_LOW : ST_IDLE;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Pad drive follows the next state so it is registered alongside it.
        drive  = (state_d == ST_PRE_LOW) || (state_d == ST_TRIG_HIGH) || (state_d == ST_POST_LOW);
        oe_d   = drive ? (NUM_CH'(1) << cur_ch_d) : '0;
        out_d  = (state_d == ST_TRIG_HIGH) ? (NUM_CH'(1) << cur_ch_d) : '0;
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state and registered outputs; reset drops the pad drive immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            echo_q   <= '0;
            cur_ch_q <= '0;
            oe_q     <= '0;
            out_q    <= '0;
            dv_q     <= 1'b0;
            mm_q     <= '0;
            dch_q    <= '0;
            to_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            echo_q   <= echo_d;
            cur_ch_q <= cur_ch_d;
            oe_q     <= oe_d;
            out_q    <= out_d;
            dv_q     <= dv_d;
            mm_q     <= mm_d;
            dch_q    <= dch_d;
            to_q     <= to_d;
            busy_q   <= busy_d;
        end
    end

    assign sensor_oe    = oe_q;
    assign sensor_out   = out_q;
    assign dist_valid   = dv_q;
    assign dist_ch      = dch_q;
    assign dist_mm      = mm_q;
    assign dist_timeout = to_q;
    assign busy         = busy_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ping_array_ctrl.sv
// Directed bench for ping_array_ctrl: trigger timing, echo conversion, timeouts,
// wrap-around, enable drop and asynchronous reset, with a result scoreboard.
module tb_ping_array_ctrl;
    import ping_pkg::*;

    localparam int NCH = 4;
    localparam int EW  = 2 + 16 + 1;   // {ch, mm, timeout}

    logic             clk;
    logic             reset;
    logic             enable;
    logic [NCH-1:0]   sensor_in;
    logic [NCH-1:0]   sensor_out;
    logic [NCH-1:0]   sensor_oe;
    logic             dist_valid;
    logic [1:0]       dist_ch;
    logic [15:0]      dist_mm;
    logic             dist_timeout;
    logic             busy;
    ping_state_e      dbg_state;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;

    ping_array_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sensor_in    (sensor_in),
        .sensor_out   (sensor_out),
        .sensor_oe    (sensor_oe),
        .dist_valid   (dist_valid),
        .dist_ch      (dist_ch),
        .dist_mm      (dist_mm),
        .dist_timeout (dist_timeout),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] ch, input logic [15:0] mm, input logic to);
        exp_q.push_back({ch, mm, to});
    endtask

    // Scoreboard monitor: every strobe pops one expected result.
    initial begin
        logic [EW-1:0] e;
        logic prev_dv;
        prev_dv = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && dist_valid) begin
                rx_cnt++;
                if (prev_dv) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_width: dist_valid high 2 cycles, required 1");
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: ch=%0d mm=%0d to=%0b, required none",
                             dist_ch, dist_mm, dist_timeout);
                end else begin
                    e = exp_q.pop_front();
                    check("result{ch,mm,to}", 32'({dist_ch, dist_mm, dist_timeout}), 32'(e));
                end
            end
            prev_dv = dist_valid;
        end
    end

    // Wait for the next trigger window and check its shape on channel ch.
    task automatic measure_trigger(input int ch);
        int w, n;
        logic [14:0] mask;
        logic [NCH-1:0] onehot, other;
        onehot = NCH'(1) << ch;
        w = 0;
        while (sensor_oe == '0 && w < 20000) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("first_oe_ch%0d", ch), 32'(sensor_oe), 32'(onehot));
        n = 0;
        mask = '0;
        other = '0;
        while (sensor_oe[ch] && n < 100) begin
            if (n < 15) mask[n] = sensor_out[ch];
            other = other | ((sensor_oe | sensor_out) & ~onehot);
            n++;
            @(negedge clk);
        end
        check($sformatf("oe_len_ch%0d", ch), 32'(n), 32'd15);
        check($sformatf("out_window_ch%0d", ch), 32'(mask), 32'h03E0);
        check($sformatf("other_ch_drive_ch%0d", ch), 32'(other), 32'd0);
    endtask

    task automatic drive_echo(input int ch, input int dly, input int width);
        repeat (dly) @(negedge clk);
        sensor_in[ch] = 1'b1;
        repeat (width) @(negedge clk);
        sensor_in[ch] = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int w;
        w = 0;
        while (rx_cnt < n && w < 20000) begin
            @(negedge clk);
            w++;
        end
        if (rx_cnt < n) check("result_timeout", 32'(rx_cnt), 32'(n));
        @(negedge clk);
    endtask

    task automatic wait_valid(output int ok);
        int w;
        w = 0;
        while (!dist_valid && w < 20000) begin
            @(negedge clk);
            w++;
        end
        ok = dist_valid;
    endtask

    // Stimulus
    initial begin
        int cnt, ok;
        logic [NCH-1:0] seen;
        reset = 1'b1;
        enable = 1'b0;
        sensor_in = '0;
        repeat (3) @(negedge clk);
        check("rst_oe", 32'(sensor_oe), 32'd0);
        check("rst_out", 32'(sensor_out), 32'd0);
        check("rst_valid", 32'(dist_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mm", 32'(dist_mm), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        enable = 1'b1;
        reset = 1'b0;

        // ch0: 1000 us echo -> 170 mm
        measure_trigger(0);
        push_exp(2'd0, 16'd170, 1'b0);
        drive_echo(0, 100, 1000);
        wait_results(1);
        repeat (10) @(negedge clk);
        check("hold_mm", 32'(dist_mm), 32'd170);
        check("hold_ch", 32'(dist_ch), 32'd0);
        check("hold_valid_low", 32'(dist_valid), 32'd0);

        // ch1: 2000 us echo -> 340 mm
        measure_trigger(1);
        push_exp(2'd1, 16'd340, 1'b0);
        drive_echo(1, 50, 2000);
        wait_results(2);

        // ch2: no echo -> timeout 6000 us after release, then gap to ch3
        measure_trigger(2);
        push_exp(2'd2, 16'hFFFF, 1'b1);
        cnt = 0;
        while (!dist_valid && cnt < 20000) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout_latency", 32'(cnt), 32'd6000);
        cnt = 0;
        while (sensor_oe == '0 && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        check("gap_len", 32'(cnt), 32'd200);

        // ch3: echo stuck high before release -> timeout
        sensor_in[3] = 1'b1;
        measure_trigger(3);
        push_exp(2'd3, 16'hFFFF, 1'b1);
        wait_results(4);
        sensor_in[3] = 1'b0;

        // wrap to ch0: 300 us -> 51 mm
        measure_trigger(0);
        push_exp(2'd0, 16'd51, 1'b0);
        drive_echo(0, 30, 300);
        wait_results(5);

        // ch1 with enable dropped mid-echo: 500 us -> 85 mm, then idle
        measure_trigger(1);
        push_exp(2'd1, 16'd85, 1'b0);
        repeat (50) @(negedge clk);
        sensor_in[1] = 1'b1;
        repeat (200) @(negedge clk);
        enable = 1'b0;
        repeat (300) @(negedge clk);
        sensor_in[1] = 1'b0;
        wait_valid(ok);
        check("endrop_valid_seen", 32'(ok), 32'd1);
        cnt = 0;
        while (busy && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check("busy_fall_after_gap", 32'(cnt), 32'd200);
        seen = '0;
        repeat (500) begin
            @(negedge clk);
            seen = seen | sensor_oe;
        end
        check("no_trigger_when_disabled", 32'(seen), 32'd0);
        check("idle_state", 32'(dbg_state), 32'(ST_IDLE));

        // Asynchronous reset during TRIG_HIGH
        enable = 1'b1;
        cnt = 0;
        while (sensor_out == '0 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check("trig_high_reached", 32'(sensor_out), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_oe", 32'(sensor_oe), 32'd0);
        check("async_rst_out", 32'(sensor_out), 32'd0);
        repeat (5) @(negedge clk);
        check("rst_busy2", 32'(busy), 32'd0);
        reset = 1'b0;
        measure_trigger(0);
        enable = 1'b0;
        push_exp(2'd0, 16'd17, 1'b0);
        drive_echo(0, 20, 100);
        wait_results(6);
        repeat (300) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_idle_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
